alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Registered decode/issue stage that produces the ALU's control and operand inputs: a, b, op (funct3) and the subtract/arithmetic-shift bit.
- Decodes RV32I integer-computational instructions (OP, OP-IMM, LUI, AUIPC), selects register or immediate operands, and flags illegal encodings.
- Sits between fetch/register-read and the ALU.
- Uses a valid/ready handshake on both sides with one register of buffering.

Parameters:
- XLEN, 32, operand width; must match the ALU.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of the held instruction
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- instr  input  32  instruction word
- pc  input  XLEN  instruction address (AUIPC)
- rs1_data  input  XLEN  register-file read of instr[19:15]
- rs2_data  input  XLEN  register-file read of instr[24:20]
- out_valid  output  1  outputs below are valid
- out_ready  input  1  ALU/writeback consumes this cycle
- alu_a  output  XLEN  ALU operand a
- alu_b  output  XLEN  ALU operand b
- alu_op  output  3  ALU op select (funct3 encoding)
- alu_sub_sra  output  1  subtract / arithmetic-shift select
- rd  output  5  destination register
- rd_we  output  1  write enable for rd
- illegal  output  1  instruction not legal for this stage

Behaviour:
- Reset (async, active-high): out_valid=0. All data outputs = 0: alu_a, alu_b, alu_op, alu_sub_sra, rd, rd_we, illegal.
- in_ready = !out_valid || out_ready. Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, register all decoded outputs and set out_valid=1. Latency: 1 cycle from accept to out_valid.
- If out_valid && out_ready && !accept: out_valid <- 0.
- Simultaneous consume and accept: the new instruction replaces the old one with no bubble. Full throughput is 1 instruction/cycle.
- While out_valid && !out_ready: all outputs hold stable. in_ready=0.
- flush=1: out_valid <- 0 next edge and any concurrent accept is discarded. Flush takes priority over accept. Data outputs may keep stale values.
- Decode, opcode instr[6:0]:
  - 0110011 OP: a=rs1_data, b=rs2_data, op=funct3.
    - sub_sra=instr[30] when funct3 in {000,101}, else 0.
    - Legal iff funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
  - 0010011 OP-IMM: a=rs1_data, b=sign-extended instr[31:20], op=funct3.
    - sub_sra=instr[30] only when funct3=101. It must be 0 for ADDI even if imm bit 10 is set.
    - funct3=001 legal iff instr[31:25]=0000000.
    - funct3=101 legal iff instr[31:25] in {0000000, 0100000}.
    - For all shifts, b[4:0]=shamt.
  - 0110111 LUI: a=0, b={instr[31:12],12'b0}, op=000, sub_sra=0.
  - 0010111 AUIPC: a=pc, b={instr[31:12],12'b0}, op=000, sub_sra=0.
  - Any other opcode: illegal=1, a=b=0, op=000, sub_sra=0.
- rd=instr[11:7] always.
- rd_we = !illegal && rd!=0.
- Illegal instructions still flow through the handshake (out_valid=1) so the trap logic sees them.
- Reset mid-transfer drops the held instruction; upstream must re-present it.

Test Plan:
- Reset: assert reset with out_ready=0 -> out_valid=0, in_ready=1, rd_we=0, illegal=0 immediately (asynchronous, before the next edge).
- ADDI x1,x0,0x400 (0x40000093), rs1_data=0 -> next cycle: alu_a=0, alu_b=0x00000400, alu_op=000, alu_sub_sra=0, rd=1, rd_we=1.
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> alu_a=10, alu_b=3, op=000, sub_sra=1, rd=3. Then SRAI x5,x6,4 (0x40435293) -> b[4:0]=4, op=101, sub_sra=1.
- LUI x7,0x12345 (0x123453B7) -> a=0, b=0x12345000, rd=7. Then AUIPC with pc=0x100 (same imm, opcode 0010111) -> a=0x100, b=0x12345000.
- Illegal: SLLI with funct7=0100000 (0x40009093) -> out_valid=1, illegal=1, rd_we=0. Opcode 0000000 -> illegal=1.
- Handshake: stream 3 instructions, out_ready low 2 cycles mid-stream -> outputs held, in_ready=0, no loss or duplication. Flush plus in_valid in the same cycle -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I OP/OP-IMM/LUI/AUIPC decoder; ports: clk, async reset, flush, in valid/ready with instr/pc/rs1_data/rs2_data, out valid/ready with alu_a/alu_b/alu_op/alu_sub_sra/rd/rd_we/illegal
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_sub_sra,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_op, is_imm, is_lui, is_auipc, addsub_shr, ill_d, ss_d, accept;
  logic [XLEN-1:0] imm_i, imm_u, a_d, b_d;
  always_comb begin
    opc        = instr[6:0];
    f3         = instr[14:12];
    f7         = instr[31:25];
    is_op      = opc == 7'b0110011;
    is_imm     = opc == 7'b0010011;
    is_lui     = opc == 7'b0110111;
    is_auipc   = opc == 7'b0010111;
    addsub_shr = f3 == 3'b000 || f3 == 3'b101;
    imm_i      = XLEN'($signed(instr[31:20]));
    imm_u      = XLEN'($signed({instr[31:12], 12'b0}));
    a_d        = (is_op || is_imm) ? rs1_data : is_auipc ? pc : '0;
    b_d        = is_op ? rs2_data : is_imm ? imm_i : (is_lui || is_auipc) ? imm_u : '0;
    // ADDI shares funct3 000 with ADD/SUB but has no alternate form, so only SRAI may set the bit
    ss_d       = is_op ? addsub_shr && instr[30] : is_imm ? f3 == 3'b101 && instr[30] : 1'b0;
    ill_d      = is_op  ? !(f7 == 7'b0000000 || (f7 == 7'b0100000 && addsub_shr)) :
                 is_imm ? (f3 == 3'b001 && f7 != 7'b0000000) ||
                          (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) :
                 !(is_lui || is_auipc);
  end
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_sub_sra <= 1'b0;
      rd          <= '0;
      rd_we       <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_a       <= a_d;
      alu_b       <= b_d;
      alu_op      <= (is_op || is_imm) ? f3 : 3'b000;
      alu_sub_sra <= ss_d;
      rd          <= instr[11:7];
      rd_we       <= !ill_d && instr[11:7] != 5'd0;
      illegal     <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: scoreboard bench with directed and random stimulus against a reference decoder
module tb_alu_decode_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ss;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0;
  logic in_ready, out_valid, alu_sub_sra, rd_we, illegal;
  logic [31:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [4:0] rd;
  exp_t q[$];
  logic acc_now = 0, mon_en = 0;
  int checks = 0, errors = 0;
  alu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_sub_sra(alu_sub_sra), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [31:0] i, p, r1, r2);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.a = r1;
        e.b = r2;
        e.op = f3;
        e.ss = (f3 == 0 || f3 == 5) ? i[30] : 1'b0;
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        e.a = r1;
        e.b = $signed(i) >>> 20;
        e.op = f3;
        e.ss = f3 == 5 && i[30];
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h37: e.b = i & 32'hfffff000;
      7'h17: begin
        e.a = p;
        e.b = i & 32'hfffff000;
      end
      default: e.ill = 1;
    endcase
    e.we = !e.ill && e.rd != 0;
    return e;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, got, want, $time);
    end
  endtask
  task automatic drive(input logic [31:0] i, p, r1, r2, input logic v, o, f,
                       input logic use_e = 0, input exp_t e = '0);
    @(negedge clk);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = v; out_ready = o; flush = f;
    #1;
    acc_now = in_valid && in_ready && !flush;
    if (acc_now) q.push_back(use_e ? e : model(i, p, r1, r2));
  endtask
  initial forever begin
    exp_t e, got;
    logic exp_valid;
    @(negedge clk);
    #4;
    if (mon_en) begin
      exp_valid = (q.size() - int'(acc_now)) > 0;
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("in_ready", {31'b0, in_ready}, {31'b0, !exp_valid || out_ready});
      if (out_valid && q.size() > 0) begin
        if (out_ready) begin
          e = q.pop_front();
          got = '{alu_a, alu_b, alu_op, alu_sub_sra, rd, rd_we, illegal};
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL output got a=%h b=%h op=%0d ss=%b rd=%0d we=%b ill=%b want a=%h b=%h op=%0d ss=%b rd=%0d we=%b ill=%b",
                     got.a, got.b, got.op, got.ss, got.rd, got.we, got.ill, e.a, e.b, e.op, e.ss, e.rd, e.we, e.ill);
          end
        end else if (flush) void'(q.pop_front());
      end
    end
  end
  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction
  initial begin
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset in_ready", {31'b0, in_ready}, 1);
    chk("reset rd_we", {31'b0, rd_we}, 0);
    chk("reset illegal", {31'b0, illegal}, 0);
    chk("reset alu_a", alu_a, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    mon_en = 1;
    drive(32'h40000093, 0, 0, 0, 1, 1, 0, 1, '{32'h0, 32'h400, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0});
    drive(32'h402081B3, 0, 10, 3, 1, 1, 0, 1, '{32'd10, 32'd3, 3'd0, 1'b1, 5'd3, 1'b1, 1'b0});
    drive(32'h40435293, 0, 32'h80000000, 0, 1, 1, 0, 1, '{32'h80000000, 32'h404, 3'd5, 1'b1, 5'd5, 1'b1, 1'b0});
    drive(32'h123453B7, 0, 32'h55, 0, 1, 1, 0, 1, '{32'h0, 32'h12345000, 3'd0, 1'b0, 5'd7, 1'b1, 1'b0});
    drive(32'h12345397, 32'h100, 32'h55, 0, 1, 1, 0, 1, '{32'h100, 32'h12345000, 3'd0, 1'b0, 5'd7, 1'b1, 1'b0});
    drive(32'h40009093, 0, 32'h77, 0, 1, 1, 0, 1, '{32'h77, 32'h400, 3'd1, 1'b0, 5'd1, 1'b0, 1'b1});
    drive(32'h00000080, 0, 32'h77, 32'h9, 1, 1, 0, 1, '{32'h0, 32'h0, 3'd0, 1'b0, 5'd1, 1'b0, 1'b1});
    drive(32'hFFF00013, 0, 5, 0, 1, 1, 0, 1, '{32'd5, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0});
    drive(32'h00208133, 0, 1, 2, 1, 1, 0);
    drive(32'h40208233, 0, 7, 2, 1, 0, 0);
    drive(32'h002081B3, 0, 4, 4, 1, 0, 0);
    drive(32'h002081B3, 0, 4, 4, 1, 0, 0);
    drive(32'h002081B3, 0, 4, 4, 1, 1, 0);
    drive(32'h002081B3, 0, 4, 4, 0, 1, 0);
    drive(32'h00100093, 0, 3, 0, 1, 0, 0);
    drive(32'h00200113, 0, 3, 0, 1, 1, 1);
    drive(32'h0, 0, 0, 0, 0, 1, 0);
    drive(32'h00300193, 0, 3, 0, 1, 0, 0);
    drive(32'h00400213, 0, 3, 0, 1, 0, 1);
    drive(32'h0, 0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 500; n++)
      drive(rand_instr(), $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    for (int n = 0; n < 4; n++) drive(0, 0, 0, 0, 0, 1, 0);
    chk("drain queue empty", q.size(), 0);
    drive(32'h123453B7, 0, 0, 0, 1, 0, 0);
    mon_en = 0;
    @(negedge clk);
    #2;
    chk("held out_valid", {31'b0, out_valid}, 1);
    reset = 1;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 0);
    chk("async reset in_ready", {31'b0, in_ready}, 1);
    chk("async reset rd_we", {31'b0, rd_we}, 0);
    chk("async reset alu_b", alu_b, 0);
    q.delete();
    @(negedge clk);
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
